burst_line_adapter: RTL



---
 rtl/burst_line_adapter_pkg.sv | 23 ++
 rtl/burst_beat_counter.sv | 39 +++
 rtl/burst_line_adapter.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/burst_line_adapter_pkg.sv
// Shared types and helpers for the burst line adapter.
// Holds the adapter FSM state encoding plus the beat-count and line-offset helpers.
package burst_line_adapter_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_RD_ISSUE,
      ST_RD_WAIT,
      ST_WR_BURST,
      ST_RESP
   } burst_state_t;

   // Number of bus beats needed to move one line.
   function automatic int beats_f(input int line_w, input int bus_w);
      return line_w / bus_w;
   endfunction

   // Number of byte-offset bits inside one line.
   function automatic int off_bits_f(input int line_w);
      return $clog2(line_w / 8);
   endfunction

endpackage

// File: rtl/burst_beat_counter.sv
// Modulo-N beat counter shared by the read and write paths.
// Ports: clk, rst (sync, active-high), clr_i, inc_i, cnt_o (current beat), last_o (cnt_o == N-1).
module burst_beat_counter #(
   parameter int N  = 4,
   parameter int CW = $clog2(N)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr_i,
   input  logic          inc_i,
   output logic [CW-1:0] cnt_o,
   output logic          last_o
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign last_o = (cnt_q == CW'(N - 1));
   assign cnt_o  = cnt_q;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i) begin
         // Wrap explicitly so the count is never used past N-1.
         cnt_d = last_o ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/burst_line_adapter.sv
// Bidirectional line-to-burst adapter between cache miss logic and the bmem port.
// Ports: clk/rst; req_* line request from cache; resp_* one-cycle response;
// bmem_* burst memory bus (command, write beats, read beats).
module burst_line_adapter
   import burst_line_adapter_pkg::*;
#(
   parameter int LINE_W = 256,
   parameter int BUS_W  = 64,
   parameter int ADDR_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [LINE_W-1:0] req_wdata,
   output logic              resp_valid,
   output logic [LINE_W-1:0] resp_rdata,
   input  logic              bmem_ready,
   output logic [ADDR_W-1:0] bmem_addr,
   output logic              bmem_read,
   output logic              bmem_write,
   output logic [BUS_W-1:0]  bmem_wdata,
   input  logic              bmem_rvalid,
   input  logic [BUS_W-1:0]  bmem_rdata
);

   localparam int BEATS = beats_f(LINE_W, BUS_W);
   localparam int OFF   = off_bits_f(LINE_W);
   localparam int CW    = $clog2(BEATS);

   burst_state_t      state_q, state_d;
   logic              wr_q,    wr_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [LINE_W-1:0] wdata_q, wdata_d;
   logic [LINE_W-1:0] buf_q,   buf_d;

   logic          cnt_clr;
   logic          cnt_inc;
   logic [CW-1:0] cnt;
   logic          cnt_last;

   burst_beat_counter #(
      .N  (BEATS),
      .CW (CW)
   ) u_cnt (
      .clk    (clk),
      .rst    (rst),
      .clr_i  (cnt_clr),
      .inc_i  (cnt_inc),
      .cnt_o  (cnt),
      .last_o (cnt_last)
   );

   always_comb begin
      state_d    = state_q;
      wr_d       = wr_q;
      addr_d     = addr_q;
      wdata_d    = wdata_q;
      buf_d      = buf_q;
      cnt_clr    = 1'b0;
      cnt_inc    = 1'b0;
      req_ready  = 1'b0;
      resp_valid = 1'b0;
      resp_rdata = '0;
      bmem_addr  = '0;
      bmem_read  = 1'b0;
      bmem_write = 1'b0;
      bmem_wdata = '0;

      unique case (state_q)
         ST_IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               wr_d    = req_write;
               addr_d  = {req_addr[ADDR_W-1:OFF], {OFF{1'b0}}};
               wdata_d = req_wdata;
               cnt_clr = 1'b1;
               // Fresh buffer per fill so a partial line never shows old data.
               if (!req_write) begin
                  buf_d = '0;
               end
               state_d = req_write ? ST_WR_BURST : ST_RD_ISSUE;
            end
         end

         ST_RD_ISSUE: begin
            bmem_addr = addr_q;
            bmem_read = bmem_ready;
            if (bmem_ready) begin
               cnt_clr = 1'b1;
               state_d = ST_RD_WAIT;
            end
         end

         ST_RD_WAIT: begin
            if (bmem_rvalid) begin
               for (int i = 0; i < BEATS; i++) begin
                  if (cnt == CW'(i)) begin
                     buf_d[i*BUS_W +: BUS_W] = bmem_rdata;
                  end
               end
               cnt_inc = 1'b1;
               if (cnt_last) begin
                  state_d = ST_RESP;
               end
            end
         end

         ST_WR_BURST: begin
            bmem_addr = addr_q;
            for (int i = 0; i < BEATS; i++) begin
               if (cnt == CW'(i)) begin
                  bmem_wdata = wdata_q[i*BUS_W +: BUS_W];
               end
            end
            // Only beat 0 waits on bmem_ready; the rest stream back to back.
            bmem_write = (cnt != '0) || bmem_ready;
            cnt_inc    = bmem_write;
            if (bmem_write && cnt_last) begin
               state_d = ST_RESP;
            end
         end

         ST_RESP: begin
            resp_valid = 1'b1;
            resp_rdata = wr_q ? '0 : buf_q;
            state_d    = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         wr_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         buf_q   <= '0;
      end else begin
         state_q <= state_d;
         wr_q    <= wr_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         buf_q   <= buf_d;
      end
   end

endmodule
